// File: rtl/fft_power_peak.sv
// Per-bin power (re^2 + im^2) over a two-stage stall-aware pipeline, with bin tagging
// and a once-per-frame peak report taken on the last-bin output transfer.
module fft_power_peak #(
   parameter int N_BINS = 16,
   parameter int W      = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_push,
   input  logic signed [W-1:0]         in_real,
   input  logic signed [W-1:0]         in_imag,
   output logic                        in_stall,
   output logic                        out_push,
   output logic [2*W-1:0]              out_power,
   output logic [$clog2(N_BINS)-1:0]   out_bin,
   output logic                        out_last,
   input  logic                        out_stall,
   output logic                        peak_valid,
   output logic [$clog2(N_BINS)-1:0]   peak_bin,
   output logic [2*W-1:0]              peak_power
);

   localparam int BW = $clog2(N_BINS);
   localparam int PW = 2 * W;
   localparam logic [BW-1:0] LAST_BIN = BW'(N_BINS - 1);
   localparam logic [BW-1:0] ZERO_BIN = {BW{1'b0}};

   logic          s1_valid_q, s1_valid_d;
   logic [PW-1:0] s1_re2_q, s1_re2_d;
   logic [PW-1:0] s1_im2_q, s1_im2_d;
   logic [BW-1:0] s1_bin_q, s1_bin_d;
   logic          s1_last_q, s1_last_d;

   logic          out_push_q, out_push_d;
   logic [PW-1:0] out_power_q, out_power_d;
   logic [BW-1:0] out_bin_q, out_bin_d;
   logic          out_last_q, out_last_d;

   logic [BW-1:0] bin_cnt_q, bin_cnt_d;
   logic [BW-1:0] run_bin_q, run_bin_d;
   logic [PW-1:0] run_pow_q, run_pow_d;

   logic          peak_valid_q, peak_valid_d;
   logic [BW-1:0] peak_bin_q, peak_bin_d;
   logic [PW-1:0] peak_power_q, peak_power_d;

   logic          s2_load_s, s1_load_s, in_xfer_s, out_xfer_s;
   logic signed [PW-1:0] re_ext_s, im_ext_s, re_sq_s, im_sq_s;
   logic [BW-1:0] cand_bin_s;
   logic [PW-1:0] cand_pow_s;

   // Handshake: a stage may load when empty or when the stage after it is moving.
   always_comb begin
      s2_load_s  = !out_push_q || !out_stall;
      s1_load_s  = !s1_valid_q || s2_load_s;
      in_stall   = reset || !s1_load_s;
      in_xfer_s  = in_push && !in_stall;
      out_xfer_s = out_push_q && !out_stall;
   end

   // Full-width signed squares so that the most negative input squares exactly.
   always_comb begin
      re_ext_s = PW'(in_real);
      im_ext_s = PW'(in_imag);
      re_sq_s  = re_ext_s * re_ext_s;
      im_sq_s  = im_ext_s * im_ext_s;
   end

   // Bin 0 seeds the running peak; otherwise only a strictly larger power replaces it.
   always_comb begin
      cand_bin_s = run_bin_q;
      cand_pow_s = run_pow_q;
      if ((out_bin_q == ZERO_BIN) || (out_power_q > run_pow_q)) begin
         cand_bin_s = out_bin_q;
         cand_pow_s = out_power_q;
      end else begin
         cand_bin_s = run_bin_q;
         cand_pow_s = run_pow_q;
      end
   end

   // Next-state for both pipeline stages, bin counter, running peak and report.
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_re2_d     = s1_re2_q;
      s1_im2_d     = s1_im2_q;
      s1_bin_d     = s1_bin_q;
      s1_last_d    = s1_last_q;
      out_push_d   = out_push_q;
      out_power_d  = out_power_q;
      out_bin_d    = out_bin_q;
      out_last_d   = out_last_q;
      bin_cnt_d    = bin_cnt_q;
      run_bin_d    = run_bin_q;
      run_pow_d    = run_pow_q;
      peak_valid_d = 1'b0;
      peak_bin_d   = peak_bin_q;
      peak_power_d = peak_power_q;

      if (s1_load_s) begin
         s1_valid_d = in_xfer_s;
         if (in_xfer_s) begin
            s1_re2_d  = $unsigned(re_sq_s);
            s1_im2_d  = $unsigned(im_sq_s);
            s1_bin_d  = bin_cnt_q;
            s1_last_d = (bin_cnt_q == LAST_BIN);
         end else begin
            s1_last_d = s1_last_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end

      if (in_xfer_s) begin
         bin_cnt_d = (bin_cnt_q == LAST_BIN) ? ZERO_BIN : bin_cnt_q + BW'(1);
      end else begin
         bin_cnt_d = bin_cnt_q;
      end

      if (s2_load_s) begin
         out_push_d = s1_valid_q;
         if (s1_valid_q) begin
            out_power_d = s1_re2_q + s1_im2_q;
            out_bin_d   = s1_bin_q;
            out_last_d  = s1_last_q;
         end else begin
            out_last_d  = out_last_q;
         end
      end else begin
         out_push_d = out_push_q;
      end

      // The report comes from the candidate, so a new bin 0 entering S2 cannot disturb it.
      if (out_xfer_s) begin
         run_bin_d = cand_bin_s;
         run_pow_d = cand_pow_s;
         if (out_last_q) begin
            peak_valid_d = 1'b1;
            peak_bin_d   = cand_bin_s;
            peak_power_d = cand_pow_s;
         end else begin
            peak_valid_d = 1'b0;
         end
      end else begin
         peak_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset; reset discards any frame in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q   <= 1'b0;
         s1_re2_q     <= {PW{1'b0}};
         s1_im2_q     <= {PW{1'b0}};
         s1_bin_q     <= ZERO_BIN;
         s1_last_q    <= 1'b0;
         out_push_q   <= 1'b0;
         out_power_q  <= {PW{1'b0}};
         out_bin_q    <= ZERO_BIN;
         out_last_q   <= 1'b0;
         bin_cnt_q    <= ZERO_BIN;
         run_bin_q    <= ZERO_BIN;
         run_pow_q    <= {PW{1'b0}};
         peak_valid_q <= 1'b0;
         peak_bin_q   <= ZERO_BIN;
         peak_power_q <= {PW{1'b0}};
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_re2_q     <= s1_re2_d;
         s1_im2_q     <= s1_im2_d;
         s1_bin_q     <= s1_bin_d;
         s1_last_q    <= s1_last_d;
         out_push_q   <= out_push_d;
         out_power_q  <= out_power_d;
         out_bin_q    <= out_bin_d;
         out_last_q   <= out_last_d;
         bin_cnt_q    <= bin_cnt_d;
         run_bin_q    <= run_bin_d;
         run_pow_q    <= run_pow_d;
         peak_valid_q <= peak_valid_d;
         peak_bin_q   <= peak_bin_d;
         peak_power_q <= peak_power_d;
      end
   end

   assign out_push   = out_push_q;
   assign out_power  = out_power_q;
   assign out_bin    = out_bin_q;
   assign out_last   = out_last_q;
   assign peak_valid = peak_valid_q;
   assign peak_bin   = peak_bin_q;
   assign peak_power = peak_power_q;

endmodule
